// File: rtl/zap_writeback_mp_if.sv
// Register-file write bus between the writeback controller and zap_register_file.
interface zap_writeback_mp_if #(
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned RW     = 6
);
    logic [NUM_WR-1:0]    wen;
    logic [NUM_WR*RW-1:0] wa;
    logic [NUM_WR*32-1:0] wdata;

    modport master (output wen, wa, wdata);
    modport slave  (input  wen, wa, wdata);
endinterface

// File: rtl/zap_writeback_mp.sv
// ZAP writeback controller: owns PC/CPSR, sequences NUM_WR register-file writes,
// takes exceptions, shelves redirects across fetch stalls and counts retirements.
module zap_writeback_mp #(
    parameter int unsigned FLAG_WDT = 32,
    parameter int unsigned PHY_REGS = 64,
    parameter int unsigned NUM_WR   = 2,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter bit          HIVEC_EN = 1'b1
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_valid,
    input  logic                          i_code_stall,
    input  logic                          i_clear_from_alu,
    input  logic [31:0]                   i_pc_from_alu,
    input  logic                          i_clear_from_decode,
    input  logic [31:0]                   i_pc_from_decode,
    input  logic [NUM_WR-1:0]             i_wr_en,
    input  logic [NUM_WR*$clog2(PHY_REGS)-1:0] i_wr_index,
    input  logic [NUM_WR*32-1:0]          i_wr_data,
    input  logic [FLAG_WDT-1:0]           i_flags,
    input  logic                          i_irq,
    input  logic                          i_fiq,
    input  logic                          i_instr_abt,
    input  logic                          i_data_abt,
    input  logic                          i_swi,
    input  logic                          i_und,
    input  logic [31:0]                   i_pc_buf_ff,
    input  logic                          i_hivec,
    zap_writeback_mp_if.master            rf,
    output logic [31:0]                   o_pc,
    output logic [31:0]                   o_pc_nxt,
    output logic [31:0]                   o_cpsr,
    output logic [31:0]                   o_cpsr_nxt,
    output logic                          o_clear_from_writeback,
    output logic                          o_shelve,
    output logic [31:0]                   o_retire_cnt
);

    localparam int unsigned RW = $clog2(PHY_REGS);

    // Physical register map shared with zap_register_file.
    localparam logic [RW-1:0] ARCH_PC          = RW'(15);
    localparam logic [RW-1:0] PHY_RAZ_REGISTER = RW'(16);
    localparam logic [RW-1:0] PHY_FIQ_R14      = RW'(23);
    localparam logic [RW-1:0] PHY_IRQ_R14      = RW'(25);
    localparam logic [RW-1:0] PHY_SVC_R14      = RW'(27);
    localparam logic [RW-1:0] PHY_UND_R14      = RW'(29);
    localparam logic [RW-1:0] PHY_ABT_R14      = RW'(31);
    localparam logic [RW-1:0] PHY_CPSR         = RW'(32);
    localparam logic [RW-1:0] PHY_FIQ_SPSR     = RW'(33);
    localparam logic [RW-1:0] PHY_IRQ_SPSR     = RW'(34);
    localparam logic [RW-1:0] PHY_SVC_SPSR     = RW'(35);
    localparam logic [RW-1:0] PHY_UND_SPSR     = RW'(36);
    localparam logic [RW-1:0] PHY_ABT_SPSR     = RW'(37);

    localparam logic [4:0] FIQ_MODE = 5'h11;
    localparam logic [4:0] IRQ_MODE = 5'h12;
    localparam logic [4:0] SVC_MODE = 5'h13;
    localparam logic [4:0] ABT_MODE = 5'h17;
    localparam logic [4:0] UND_MODE = 5'h1B;

    localparam int unsigned I_BIT = 7;
    localparam int unsigned F_BIT = 6;
    localparam int unsigned T_BIT = 5;

    localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;

    typedef enum logic {RUN = 1'b0, SHELVED = 1'b1} state_t;

    state_t      state_ff, state_nxt;
    logic [31:0] pc_ff, pc_nxt;
    logic [31:0] cpsr_ff, cpsr_nxt;
    logic [31:0] shelf_ff, shelf_nxt;
    logic [31:0] retire_ff;

    logic          fiq_q, irq_q;
    logic          exc_take, exc_fiq;
    logic [4:0]    exc_mode;
    logic [31:0]   exc_off;
    logic [RW-1:0] exc_lr, exc_spsr;

    logic [NUM_WR-1:0]    wen_c;
    logic [NUM_WR*RW-1:0] wa_c;
    logic [NUM_WR*32-1:0] wdata_c;
    logic                 clear_c;
    logic                 wb_redirect;
    logic [31:0]          wb_target;
    logic                 retire;
    logic                 pc_hit, cpsr_hit;
    logic [31:0]          pc_data, cpsr_data, hi_data;
    logic [31:0]          vec_base;

    assign fiq_q    = i_fiq & ~cpsr_ff[F_BIT];
    assign irq_q    = i_irq & ~cpsr_ff[I_BIT];
    assign vec_base = (HIVEC_EN && i_hivec) ? 32'hFFFF_0000 : 32'h0;

    // Pick the highest-priority unmasked exception and its mode/vector/banked slots.
    always_comb begin
        exc_take = 1'b1;
        exc_fiq  = 1'b0;
        exc_mode = SVC_MODE;
        exc_off  = 32'h0;
        exc_lr   = PHY_RAZ_REGISTER;
        exc_spsr = PHY_RAZ_REGISTER;
        if (i_data_abt) begin
            exc_mode = ABT_MODE; exc_off = 32'h10; exc_lr = PHY_ABT_R14; exc_spsr = PHY_ABT_SPSR;
        end else if (fiq_q) begin
            exc_fiq  = 1'b1;
            exc_mode = FIQ_MODE; exc_off = 32'h1C; exc_lr = PHY_FIQ_R14; exc_spsr = PHY_FIQ_SPSR;
        end else if (irq_q) begin
            exc_mode = IRQ_MODE; exc_off = 32'h18; exc_lr = PHY_IRQ_R14; exc_spsr = PHY_IRQ_SPSR;
        end else if (i_instr_abt) begin
            exc_mode = ABT_MODE; exc_off = 32'h0C; exc_lr = PHY_ABT_R14; exc_spsr = PHY_ABT_SPSR;
        end else if (i_swi) begin
            exc_mode = SVC_MODE; exc_off = 32'h08; exc_lr = PHY_SVC_R14; exc_spsr = PHY_SVC_SPSR;
        end else if (i_und) begin
            exc_mode = UND_MODE; exc_off = 32'h04; exc_lr = PHY_UND_R14; exc_spsr = PHY_UND_SPSR;
        end else begin
            exc_take = 1'b0;
        end
    end

    // Scan write ports: lowest PC/CPSR hit wins, highest enabled port supplies CPSR on PC writes.
    always_comb begin
        pc_hit    = 1'b0;
        cpsr_hit  = 1'b0;
        pc_data   = 32'h0;
        cpsr_data = 32'h0;
        hi_data   = 32'h0;
        for (int k = NUM_WR - 1; k >= 0; k--) begin
            if (i_wr_en[k] && (i_wr_index[k*RW +: RW] == ARCH_PC)) begin
                pc_hit  = 1'b1;
                pc_data = i_wr_data[k*32 +: 32];
            end
            if (i_wr_en[k] && (i_wr_index[k*RW +: RW] == PHY_CPSR)) begin
                cpsr_hit  = 1'b1;
                cpsr_data = i_wr_data[k*32 +: 32];
            end
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (i_wr_en[k]) hi_data = i_wr_data[k*32 +: 32];
        end
    end

    // Register-file writes, flush and next CPSR for this cycle.
    always_comb begin
        wen_c       = '0;
        wa_c        = {NUM_WR{PHY_RAZ_REGISTER}};
        wdata_c     = '0;
        clear_c     = 1'b0;
        wb_redirect = 1'b0;
        wb_target   = 32'h0;
        retire      = 1'b0;
        cpsr_nxt    = cpsr_ff;
        if (exc_take) begin
            wen_c[0]         = 1'b1;
            wen_c[1]         = 1'b1;
            wa_c[0 +: RW]    = exc_lr;
            wa_c[RW +: RW]   = exc_spsr;
            wdata_c[31:0]    = cpsr_ff[T_BIT] ? (i_pc_buf_ff - 32'd2) : i_pc_buf_ff;
            wdata_c[63:32]   = cpsr_ff;
            clear_c          = 1'b1;
            wb_redirect      = 1'b1;
            wb_target        = vec_base + exc_off;
            cpsr_nxt[4:0]    = exc_mode;
            cpsr_nxt[I_BIT]  = 1'b1;
            cpsr_nxt[T_BIT]  = 1'b0;
            if (exc_fiq) cpsr_nxt[F_BIT] = 1'b1;
        end else if (i_valid) begin
            wen_c   = i_wr_en;
            wa_c    = i_wr_index;
            wdata_c = i_wr_data;
            retire  = 1'b1;
            if (pc_hit) begin
                clear_c     = 1'b1;
                wb_redirect = 1'b1;
                wb_target   = pc_data;
                cpsr_nxt    = hi_data;
            end else if (cpsr_hit) begin
                cpsr_nxt = cpsr_data;
            end else begin
                cpsr_nxt = 32'(i_flags);
            end
        end
    end

    // Next PC and shelve state: redirects park in the shelf while fetch is stalled.
    always_comb begin
        logic        redir;
        logic [31:0] redir_pc;
        pc_nxt    = pc_ff;
        state_nxt = state_ff;
        shelf_nxt = shelf_ff;
        redir     = 1'b1;
        redir_pc  = wb_target;
        if (wb_redirect) begin
            redir_pc = wb_target;
        end else if (i_clear_from_alu) begin
            redir_pc = i_pc_from_alu;
        end else if (i_clear_from_decode) begin
            redir_pc = i_pc_from_decode;
        end else begin
            redir = 1'b0;
        end

        if (redir) begin
            if (i_code_stall) begin
                shelf_nxt = redir_pc;
                state_nxt = SHELVED;
            end else begin
                pc_nxt    = redir_pc;
                state_nxt = RUN;
            end
        end else if (i_code_stall) begin
            pc_nxt = pc_ff;
        end else if (state_ff == SHELVED) begin
            pc_nxt    = shelf_ff;
            state_nxt = RUN;
        end else begin
            pc_nxt = pc_ff + (cpsr_ff[T_BIT] ? 32'd2 : 32'd4);
        end
        pc_nxt[0] = 1'b0;
    end

    // Architectural state registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc_ff     <= RESET_PC;
            cpsr_ff   <= CPSR_RESET;
            state_ff  <= RUN;
            shelf_ff  <= 32'h0;
            retire_ff <= 32'h0;
        end else begin
            pc_ff    <= pc_nxt;
            cpsr_ff  <= cpsr_nxt;
            state_ff <= state_nxt;
            shelf_ff <= shelf_nxt;
            if (retire) retire_ff <= retire_ff + 32'd1;
        end
    end

    assign rf.wen                 = wen_c;
    assign rf.wa                  = wa_c;
    assign rf.wdata               = wdata_c;
    assign o_clear_from_writeback = clear_c;
    assign o_pc                   = pc_ff;
    assign o_pc_nxt               = pc_nxt;
    assign o_cpsr                 = cpsr_ff;
    assign o_cpsr_nxt             = cpsr_nxt;
    assign o_shelve               = (state_ff == SHELVED);
    assign o_retire_cnt           = retire_ff;

endmodule

// File: tb/tb_zap_writeback_mp.sv
// Directed bench for zap_writeback_mp with a per-cycle behavioural model.
module tb_zap_writeback_mp;

    localparam int unsigned NUM_WR = 2;
    localparam int unsigned RW     = 6;

    localparam logic [5:0] R_PC   = 6'd15;
    localparam logic [5:0] R_RAZ  = 6'd16;
    localparam logic [5:0] R_CPSR = 6'd32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid, i_code_stall, i_clear_from_alu, i_clear_from_decode;
    logic [31:0] i_pc_from_alu, i_pc_from_decode, i_pc_buf_ff;
    logic [1:0]  i_wr_en;
    logic [11:0] i_wr_index;
    logic [63:0] i_wr_data;
    logic [31:0] i_flags;
    logic        i_irq, i_fiq, i_instr_abt, i_data_abt, i_swi, i_und, i_hivec;
    logic [31:0] o_pc, o_pc_nxt, o_cpsr, o_cpsr_nxt, o_retire_cnt;
    logic        o_clear_from_writeback, o_shelve;

    zap_writeback_mp_if #(.NUM_WR(NUM_WR), .RW(RW)) rf ();

    zap_writeback_mp #(
        .FLAG_WDT(32), .PHY_REGS(64), .NUM_WR(NUM_WR), .RESET_PC(32'h0), .HIVEC_EN(1'b1)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .i_code_stall(i_code_stall),
        .i_clear_from_alu(i_clear_from_alu), .i_pc_from_alu(i_pc_from_alu),
        .i_clear_from_decode(i_clear_from_decode), .i_pc_from_decode(i_pc_from_decode),
        .i_wr_en(i_wr_en), .i_wr_index(i_wr_index), .i_wr_data(i_wr_data), .i_flags(i_flags),
        .i_irq(i_irq), .i_fiq(i_fiq), .i_instr_abt(i_instr_abt), .i_data_abt(i_data_abt),
        .i_swi(i_swi), .i_und(i_und), .i_pc_buf_ff(i_pc_buf_ff), .i_hivec(i_hivec),
        .rf(rf), .o_pc(o_pc), .o_pc_nxt(o_pc_nxt), .o_cpsr(o_cpsr), .o_cpsr_nxt(o_cpsr_nxt),
        .o_clear_from_writeback(o_clear_from_writeback), .o_shelve(o_shelve),
        .o_retire_cnt(o_retire_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model state: PC, CPSR, an optional pending redirect, retire count.
    logic [31:0] m_pc, m_cpsr, m_pend_pc, m_retire;
    bit          m_pend;
    // Model predictions for the current cycle.
    logic [1:0]  e_wen;
    logic [11:0] e_wa;
    logic [63:0] e_wd;
    logic        e_clear;
    bit          e_retire, e_pend;
    logic [31:0] e_pc_nxt, e_cpsr_nxt, e_pend_pc;

    function automatic logic [5:0] lr_of(input logic [4:0] mode);
        case (mode)
            5'h11:   return 6'd23;
            5'h12:   return 6'd25;
            5'h13:   return 6'd27;
            5'h1B:   return 6'd29;
            default: return 6'd31;
        endcase
    endfunction

    function automatic logic [5:0] spsr_of(input logic [4:0] mode);
        case (mode)
            5'h11:   return 6'd33;
            5'h12:   return 6'd34;
            5'h13:   return 6'd35;
            5'h1B:   return 6'd36;
            default: return 6'd37;
        endcase
    endfunction

    function automatic void model_eval();
        int          ex;
        logic [4:0]  mode;
        logic [31:0] off, tgt, pc_d, cpsr_d, hi_d;
        bit          go, pc_w, cpsr_w;
        e_wen = 2'b00; e_wa = {R_RAZ, R_RAZ}; e_wd = 64'h0;
        e_clear = 1'b0; e_retire = 1'b0; e_cpsr_nxt = m_cpsr;
        go = 1'b0; tgt = 32'h0; mode = 5'h0; off = 32'h0;
        pc_d = 32'h0; cpsr_d = 32'h0; hi_d = 32'h0; pc_w = 1'b0; cpsr_w = 1'b0;
        ex = 0;
        if (i_data_abt)                 ex = 1;
        else if (i_fiq && !m_cpsr[6])   ex = 2;
        else if (i_irq && !m_cpsr[7])   ex = 3;
        else if (i_instr_abt)           ex = 4;
        else if (i_swi)                 ex = 5;
        else if (i_und)                 ex = 6;
        case (ex)
            1: begin mode = 5'h17; off = 32'h10; end
            2: begin mode = 5'h11; off = 32'h1C; end
            3: begin mode = 5'h12; off = 32'h18; end
            4: begin mode = 5'h17; off = 32'h0C; end
            5: begin mode = 5'h13; off = 32'h08; end
            6: begin mode = 5'h1B; off = 32'h04; end
            default: ;
        endcase
        if (ex != 0) begin
            e_wen      = 2'b11;
            e_wa       = {spsr_of(mode), lr_of(mode)};
            e_wd       = {m_cpsr, m_cpsr[5] ? i_pc_buf_ff - 32'd2 : i_pc_buf_ff};
            e_clear    = 1'b1;
            go         = 1'b1;
            tgt        = (i_hivec ? 32'hFFFF_0000 : 32'h0) + off;
            e_cpsr_nxt = {m_cpsr[31:8], 1'b1, m_cpsr[6] | (ex == 2), 1'b0, mode};
        end else if (i_valid) begin
            e_wen = i_wr_en; e_wa = i_wr_index; e_wd = i_wr_data; e_retire = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (i_wr_en[k]) hi_d = i_wr_data[k*32 +: 32];
                if (i_wr_en[k] && !pc_w && i_wr_index[k*6 +: 6] == R_PC) begin
                    pc_w = 1'b1; pc_d = i_wr_data[k*32 +: 32];
                end
                if (i_wr_en[k] && !cpsr_w && i_wr_index[k*6 +: 6] == R_CPSR) begin
                    cpsr_w = 1'b1; cpsr_d = i_wr_data[k*32 +: 32];
                end
            end
            if (pc_w) begin
                go = 1'b1; tgt = pc_d; e_clear = 1'b1; e_cpsr_nxt = hi_d;
            end else if (cpsr_w) begin
                e_cpsr_nxt = cpsr_d;
            end else begin
                e_cpsr_nxt = i_flags;
            end
        end
        if (!go && i_clear_from_alu) begin
            go = 1'b1; tgt = i_pc_from_alu;
        end else if (!go && i_clear_from_decode) begin
            go = 1'b1; tgt = i_pc_from_decode;
        end
        e_pend = m_pend; e_pend_pc = m_pend_pc;
        if (go && i_code_stall) begin
            e_pc_nxt = m_pc; e_pend = 1'b1; e_pend_pc = tgt;
        end else if (go) begin
            e_pc_nxt = tgt; e_pend = 1'b0;
        end else if (i_code_stall) begin
            e_pc_nxt = m_pc;
        end else if (m_pend) begin
            e_pc_nxt = m_pend_pc; e_pend = 1'b0;
        end else begin
            e_pc_nxt = m_pc + (m_cpsr[5] ? 32'd2 : 32'd4);
        end
        e_pc_nxt[0] = 1'b0;
    endfunction

    // Compare every output against the model once per cycle, mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            model_eval();
            chk("pc",       o_pc,                   m_pc);
            chk("cpsr",     o_cpsr,                 m_cpsr);
            chk("shelve",   o_shelve,               m_pend);
            chk("retire",   o_retire_cnt,           m_retire);
            chk("wen",      rf.wen,                 e_wen);
            chk("wa",       rf.wa,                  e_wa);
            chk("wdata",    rf.wdata,               e_wd);
            chk("clear",    o_clear_from_writeback, e_clear);
            chk("pc_nxt",   o_pc_nxt,               e_pc_nxt);
            chk("cpsr_nxt", o_cpsr_nxt,             e_cpsr_nxt);
        end
    end

    // Advance the model on each clock; async reset clears it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h0; m_cpsr <= 32'h0000_00D3; m_pend <= 1'b0;
            m_pend_pc <= 32'h0; m_retire <= 32'h0;
        end else if (started) begin
            m_pc <= e_pc_nxt; m_cpsr <= e_cpsr_nxt; m_pend <= e_pend;
            m_pend_pc <= e_pend_pc; m_retire <= m_retire + (e_retire ? 32'd1 : 32'd0);
        end
    end

    task automatic idle();
        i_valid = 0; i_code_stall = 0; i_clear_from_alu = 0; i_clear_from_decode = 0;
        i_pc_from_alu = 0; i_pc_from_decode = 0; i_pc_buf_ff = 0;
        i_wr_en = 0; i_wr_index = {R_RAZ, R_RAZ}; i_wr_data = 0; i_flags = 0;
        i_irq = 0; i_fiq = 0; i_instr_abt = 0; i_data_abt = 0; i_swi = 0; i_und = 0; i_hivec = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Retire one instruction that only updates flags.
    task automatic set_flags(input logic [31:0] f);
        i_valid = 1; i_wr_en = 2'b00; i_flags = f;
        step();
        idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        step();
        started = 1'b1;
        step();
        chk("rst_pc",     o_pc,                   32'h0);
        chk("rst_mode",   o_cpsr[4:0],            5'h13);
        chk("rst_if",     o_cpsr[7:6],            2'b11);
        chk("rst_retire", o_retire_cnt,           32'h0);
        chk("rst_wen",    rf.wen,                 2'b00);
        chk("rst_clear",  o_clear_from_writeback, 1'b0);
        rst_n = 1;
        step(); chk("seq_pc4",  o_pc, 32'd4);
        step(); chk("seq_pc8",  o_pc, 32'd8);
        step(); chk("seq_pc12", o_pc, 32'd12);

        // IRQ with I clear, high vectors
        set_flags(32'h10);
        i_irq = 1; i_pc_buf_ff = 32'h108; i_hivec = 1;
        #1;
        chk("irq_clear", o_clear_from_writeback, 1'b1);
        chk("irq_lr_a",  rf.wa[5:0],             6'd25);
        chk("irq_lr_d",  rf.wdata[31:0],         32'h108);
        chk("irq_spsr",  rf.wa[11:6],            6'd34);
        step(); idle();
        chk("irq_pc",   o_pc,        32'hFFFF_0018);
        chk("irq_cpsr", o_cpsr,      32'h92);

        // FIQ masked by F, instruction writes R1
        set_flags(32'h50);
        i_fiq = 1; i_valid = 1; i_wr_en = 2'b01; i_wr_index = {6'd0, 6'd1};
        i_wr_data = {32'h0, 32'h5}; i_flags = 32'h50;
        #1;
        chk("fiqm_clear", o_clear_from_writeback, 1'b0);
        chk("fiqm_wen",   rf.wen,                 2'b01);
        chk("fiqm_wd",    rf.wdata[31:0],         32'h5);
        step(); idle();
        chk("fiqm_retire", o_retire_cnt, 32'd3);
        chk("fiqm_pc",     o_pc,         32'hFFFF_0020);

        // Data abort beats IRQ in Thumb state
        set_flags(32'h30);
        i_data_abt = 1; i_irq = 1; i_pc_buf_ff = 32'h200;
        #1;
        chk("dabt_lr_a", rf.wa[5:0],     6'd31);
        chk("dabt_lr_d", rf.wdata[31:0], 32'h1FE);
        chk("dabt_spsr", rf.wdata[63:32], 32'h30);
        step(); idle();
        chk("dabt_pc",   o_pc,   32'h10);
        chk("dabt_cpsr", o_cpsr, 32'h97);

        // PC write on port 1 under a 3-cycle fetch stall
        i_valid = 1; i_wr_en = 2'b10; i_wr_index = {R_PC, R_RAZ};
        i_wr_data = {32'h3001, 32'h0}; i_code_stall = 1;
        #1;
        chk("shv_clear", o_clear_from_writeback, 1'b1);
        step(); idle(); i_code_stall = 1;
        chk("shv_on",  o_shelve, 1'b1);
        chk("shv_pc1", o_pc,     32'h10);
        step(); chk("shv_pc2", o_pc, 32'h10);
        step(); chk("shv_pc3", o_pc, 32'h10);
        i_code_stall = 0;
        step();
        chk("shv_pc",  o_pc,     32'h3000);
        chk("shv_off", o_shelve, 1'b0);

        // A later redirect overwrites the shelved target
        i_code_stall = 1; i_clear_from_alu = 1; i_pc_from_alu = 32'h4000;
        step(); i_clear_from_alu = 0;
        i_clear_from_decode = 1; i_pc_from_decode = 32'h5000;
        step(); i_clear_from_decode = 0;
        chk("ovr_hold", o_pc, 32'h3000);
        i_code_stall = 0;
        step();
        chk("ovr_pc", o_pc, 32'h5000);

        // Async reset while shelved drops the latched PC
        i_code_stall = 1; i_clear_from_alu = 1; i_pc_from_alu = 32'h7000;
        step(); i_clear_from_alu = 0;
        chk("ars_shv", o_shelve, 1'b1);
        #2; rst_n = 0; #1;
        chk("ars_shelve", o_shelve, 1'b0);
        chk("ars_pc",     o_pc,     32'h0);
        chk("ars_cpsr",   o_cpsr,   32'hD3);
        idle();
        step(); rst_n = 1;
        step();
        chk("ars_rel_pc", o_pc, 32'd4);

        // Two PC writes: lowest port wins, highest enabled port loads CPSR
        i_valid = 1; i_wr_en = 2'b11; i_wr_index = {R_PC, R_PC};
        i_wr_data = {32'h700, 32'h600};
        step(); idle();
        chk("pc2_pc",   o_pc,   32'h600);
        chk("pc2_cpsr", o_cpsr, 32'h700);

        // Two CPSR writes: lowest port wins
        i_valid = 1; i_wr_en = 2'b11; i_wr_index = {R_CPSR, R_CPSR};
        i_wr_data = {32'h10, 32'h1F};
        step(); idle();
        chk("cw_cpsr", o_cpsr, 32'h1F);

        // SWI / prefetch abort / undefined vectors
        i_swi = 1; i_hivec = 1; i_pc_buf_ff = 32'h40;
        step(); idle();
        chk("swi_pc",   o_pc,        32'hFFFF_0008);
        chk("swi_mode", o_cpsr[4:0], 5'h13);
        i_instr_abt = 1; i_pc_buf_ff = 32'h44;
        step(); idle();
        chk("pabt_pc",   o_pc,        32'h0C);
        chk("pabt_mode", o_cpsr[4:0], 5'h17);
        i_und = 1; i_pc_buf_ff = 32'h48;
        step(); idle();
        chk("und_pc",   o_pc,        32'h04);
        chk("und_mode", o_cpsr[4:0], 5'h1B);

        // IRQ masked by I after exception entry
        i_irq = 1;
        #1;
        chk("irqm_clear", o_clear_from_writeback, 1'b0);
        step(); idle();
        chk("irqm_pc", o_pc, 32'h08);

        step(); step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
